input_dispatcher: RTL and testbench
===================================

// Module: input_dispatcher
// PURPOSE
//  Feeds the shared io_in sample bus of the rede_taylor core array. The output collector
//  gathers results from the cores; this block serves the other direction. It buffers
//  upstream samples in a FIFO and answers each core's req_in request. A round-robin
//  arbiter grants one core at a time. The granted core then receives its requested burst
//  of samples, each one qualified by a one-hot select strobe.
// PARAMETERS
//  NCORES  37  number of cores served
//  DW      19  sample width (matches signed io_in)
//  REQW    4   width of each core's req_in (burst length request, 0 = idle)
//  DEPTH   16  sample FIFO depth (power of two)
//  IDW     6   width of grant_id, ceil(log2(NCORES))
// PORTS
//  clk        in   1            system clock, rising edge
//  rst        in   1            synchronous, active-low reset (rst==0 resets on clk edge)
//  s_data     in   DW           upstream sample, signed
//  s_valid    in   1            s_data valid
//  s_ready    out  1            FIFO can accept; push occurs when s_valid&&s_ready
//  req_flat   in   NCORES*REQW  core k request at [k*REQW +: REQW]; value = samples wanted
//  io_in      out  DW           shared sample bus to all cores, signed
//  in_valid   out  1            io_in carries a new sample this cycle
//  in_sel     out  NCORES       one-hot target core; nonzero only while in_valid=1
//  grant_id   out  IDW          index of the currently/last granted core
//  busy       out  1            high in ARB, SEND and GAP states
//  fill       out  log2(DEPTH)+1 FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (rst==0 at clk edge):
//   - State goes to IDLE; FIFO is emptied.
//   - io_in=0, in_valid=0, in_sel=0, grant_id=0, busy=0, fill=0.
//   - Round-robin pointer rr=NCORES-1, so core 0 has first priority.
//   - The current burst is aborted. No partial delivery resumes after reset.
//  FIFO:
//   - s_ready = (fill<DEPTH). A push is not accepted when full, even if a pop occurs in
//     the same cycle.
//   - A push and a pop in the same cycle leave fill unchanged.
//   - Pointers wrap modulo DEPTH.
//  FSM states: IDLE -> ARB -> SEND -> GAP -> IDLE.
//   - IDLE: if any req field is nonzero, go to ARB the next cycle.
//   - ARB (1 cycle): pick the first core with a nonzero req, scanning from rr+1 upward
//     modulo NCORES.
//     - Latch that core's index into grant_id and rr.
//     - Latch its req value into remaining (1..2^REQW-1).
//     - Go to SEND.
//     - If no request is still pending, return to IDLE; grant_id is unchanged.
//   - SEND, each cycle:
//     - If FIFO is non-empty: pop the head and register it onto io_in. in_valid=1,
//       in_sel=1<<grant_id, remaining-=1.
//     - If FIFO is empty: in_valid=0, in_sel=0, io_in holds its last value (stall; no
//       timeout).
//     - When the pop makes remaining 0, go to GAP.
//   - GAP (2 cycles): in_valid=0. This gives the core time to drop req_in, so a stale
//     request is not re-granted. Then go to IDLE.
//  Latency and ordering:
//   - A sample pushed into an empty FIFO can appear on io_in no earlier than 1 cycle
//     later (registered pop).
//   - Samples are delivered in FIFO order. No sample is duplicated or skipped.
//  Request sampling:
//   - A core's req value is sampled only in ARB.
//   - Changes to req during SEND are ignored until the next ARB.
//  Fairness: after core k is served, every other requesting core is served before k again.
//  Back-to-back fill: s_valid held with a stalled SEND delivers at 1 sample/clk once data
//  arrives.
// TESTING
//  1 Reset: hold rst=0 for 3 clk with s_valid=1 and all req=5
//    -> all outputs 0, s_ready=1, fill=0 throughout.
//  2 Single burst: push 8 samples (values 1..8); core 3 req=4
//    -> io_in = 1,2,3,4 on 4 consecutive in_valid cycles, in_sel=1<<3, grant_id=3,
//       then fill=4 and 2 GAP cycles.
//  3 Round robin: cores 0, 5 and 36 each req=1 and keep requesting; FIFO pre-filled
//    -> grant order 0,5,36,0,5; each gets exactly 1 sample per grant.
//  4 Starvation stall: core 7 req=3 with FIFO empty; push 1 sample every 4 clk
//    -> in_valid pulses 3 times, spaced 4 clk apart; busy=1 until the GAP completes.
//  5 Full/simultaneous: fill FIFO to 16 with s_valid held high
//    -> s_ready=0, the extra sample is not taken. Then core 0 req=1 -> one pop, s_ready=1
//       the next cycle, and the held sample is accepted.
//  6 Reset mid-burst: core 2 req=15; assert rst=0 after 6 deliveries
//    -> next cycle in_valid=0, fill=0, state IDLE; after release, a fresh ARB grants from
//       core 0.

Source files
------------

// File: rtl/input_dispatcher.sv
// rtl/input_dispatcher.sv - sample FIFO with round-robin burst dispatch onto the shared io_in bus
module input_dispatcher #(
  parameter  int NCORES = 37,
  parameter  int DW     = 19,
  parameter  int REQW   = 4,
  parameter  int DEPTH  = 16,
  parameter  int IDW    = 6,
  localparam int AW     = $clog2(DEPTH),
  localparam int FW     = AW + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DW-1:0]     s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [NCORES*REQW-1:0]   req_flat,
  output logic signed [DW-1:0]     io_in,
  output logic                     in_valid,
  output logic [NCORES-1:0]        in_sel,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy,
  output logic [FW-1:0]            fill
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_SEND,
    S_GAP1,
    S_GAP2
  } state_t;

  state_t                  state_q, state_d;
  logic [DW-1:0]           mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]           fill_q, fill_d;
  logic [IDW-1:0]          rr_q, rr_d;
  logic [IDW-1:0]          grant_q, grant_d;
  logic [REQW-1:0]         rem_q, rem_d;
  logic signed [DW-1:0]    io_q, io_d;
  logic                    valid_q, valid_d;
  logic [NCORES-1:0]       sel_q, sel_d;

  logic                    push, pop;
  logic                    found;
  logic [IDW-1:0]          pick;
  logic [REQW-1:0]         pick_req;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign push     = s_valid && (fill_q < FW'(DEPTH));
  assign pop      = (state_q == S_SEND) && (fill_q != '0);
  assign s_ready  = (fill_q < FW'(DEPTH));
  assign busy     = (state_q != S_IDLE);
  assign fill     = fill_q;
  assign io_in    = io_q;
  assign in_valid = valid_q;
  assign in_sel   = sel_q;
  assign grant_id = grant_q;

  // Round-robin search: first nonzero request starting just after the last grant.
  always_comb begin
    int idx;
    found    = 1'b0;
    pick     = '0;
    pick_req = '0;
    idx      = 0;
    for (int i = 0; i < NCORES; i++) begin
      idx = (int'(rr_q) + 1 + i) % NCORES;
      if (!found && (req_flat[idx*REQW +: REQW] != '0)) begin
        found    = 1'b1;
        pick     = IDW'(idx);
        pick_req = req_flat[idx*REQW +: REQW];
      end
    end
  end

  // Next-state and registered-output logic for the dispatch FSM.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    rem_d   = rem_q;
    io_d    = io_q;
    valid_d = 1'b0;
    sel_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (|req_flat) state_d = S_ARB;
      end
      S_ARB: begin
        if (found) begin
          grant_d = pick;
          rr_d    = pick;
          rem_d   = pick_req;
          state_d = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (pop) begin
          io_d    = mem_q[rd_ptr_q];
          valid_d = 1'b1;
          sel_d   = NCORES'(1) << grant_q;
          rem_d   = rem_q - 1'b1;
          if (rem_q == REQW'(1)) state_d = S_GAP1;
        end
      end
      S_GAP1:  state_d = S_GAP2;
      S_GAP2:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Occupancy follows push/pop; simultaneous push and pop cancel out.
  always_comb begin
    fill_d = fill_q;
    if (push && !pop)      fill_d = fill_q + 1'b1;
    else if (pop && !push) fill_d = fill_q - 1'b1;
  end

  // State, pointers and outputs; reset aborts any burst and empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      rr_q     <= IDW'(NCORES - 1);
      grant_q  <= '0;
      rem_q    <= '0;
      io_q     <= '0;
      valid_q  <= 1'b0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      rem_q    <= rem_d;
      io_q     <= io_d;
      valid_q  <= valid_d;
      sel_q    <= sel_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Sample storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

endmodule

// File: tb/tb_input_dispatcher.sv
// tb/tb_input_dispatcher.sv - self-checking bench for input_dispatcher
module tb_input_dispatcher;

  localparam int NCORES = 37;
  localparam int DW     = 19;
  localparam int REQW   = 4;
  localparam int DEPTH  = 16;
  localparam int IDW    = 6;
  localparam int FW     = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [DW-1:0]          s_data;
  logic                   s_valid;
  logic                   s_ready;
  logic [NCORES*REQW-1:0] req_flat;
  logic [DW-1:0]          io_in;
  logic                   in_valid;
  logic [NCORES-1:0]      in_sel;
  logic [IDW-1:0]         grant_id;
  logic                   busy;
  logic [FW-1:0]          fill;

  input_dispatcher dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .req_flat (req_flat),
    .io_in    (io_in),
    .in_valid (in_valid),
    .in_sel   (in_sel),
    .grant_id (grant_id),
    .busy     (busy),
    .fill     (fill)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] exp_q[$];
  int reqv[NCORES];
  int last_g, exp_core, rem, grants_left, dcount, cyc;
  int dcyc[$];
  int gid_log[$];
  int cmp_cnt, err_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    cmp_cnt++;
    assert (got === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int next_req(input int last);
    int c;
    for (int i = 1; i <= NCORES; i++) begin
      c = (last + i) % NCORES;
      if (reqv[c] != 0) return c;
    end
    return -1;
  endfunction

  task automatic drive_req();
    for (int k = 0; k < NCORES; k++) req_flat[k*REQW +: REQW] = REQW'(reqv[k]);
  endtask

  task automatic clear_req();
    for (int k = 0; k < NCORES; k++) reqv[k] = 0;
    drive_req();
  endtask

  task automatic start_grants(input int n);
    grants_left = n;
    exp_core    = next_req(last_g);
    rem         = (exp_core >= 0) ? reqv[exp_core] : 0;
  endtask

  // One clock: apply the edge, then settle the model against what the DUT shows.
  task automatic tick();
    bit in_rst, acc;
    logic [DW-1:0] pd, e;
    logic [NCORES-1:0] oh;
    in_rst = !rst;
    acc    = s_valid && rst && (exp_q.size() < DEPTH);
    pd     = s_data;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (in_rst) begin
      exp_q.delete();
      grants_left = 0;
      last_g      = NCORES - 1;
      chk("rst_in_valid", in_valid, 0);
      chk("rst_in_sel", in_sel, 0);
      chk("rst_io_in", io_in, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_busy", busy, 0);
    end else if (in_valid) begin
      dcyc.push_back(cyc);
      gid_log.push_back(int'(grant_id));
      if (grants_left == 0) begin
        chk("spurious_valid", in_valid, 0);
      end else begin
        oh = '0;
        oh[exp_core] = 1'b1;
        chk("in_sel", in_sel, oh);
        chk("grant_id", grant_id, exp_core);
        if (exp_q.size() == 0) chk("data_underflow", in_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("io_in", io_in, e);
        end
        dcount++;
        rem--;
        if (rem == 0) begin
          last_g = exp_core;
          grants_left--;
          if (grants_left > 0) begin
            exp_core = next_req(last_g);
            rem      = reqv[exp_core];
          end else begin
            clear_req();
          end
        end
      end
    end else begin
      chk("in_sel_idle", in_sel, 0);
    end
    if (acc) exp_q.push_back(pd);
    chk("fill", fill, exp_q.size());
    chk("s_ready", s_ready, exp_q.size() < DEPTH);
  endtask

  task automatic do_reset();
    clear_req();
    s_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic prefill(input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = DW'($urandom);
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic run_grants(input int bound, input int prob);
    int n;
    n = 0;
    while (grants_left > 0 && n < bound) begin
      s_valid = ($urandom_range(99) < prob);
      s_data  = DW'($urandom);
      tick();
      n++;
    end
    s_valid = 1'b0;
    chk("grant_timeout", grants_left, 0);
  endtask

  task automatic gap_check(input string pfx);
    chk({pfx, "_gap1_busy"}, busy, 1);
    tick();
    chk({pfx, "_gap2_busy"}, busy, 1);
    chk({pfx, "_gap2_valid"}, in_valid, 0);
    tick();
    chk({pfx, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int exp3[5];
    int pushes, d0, n;
    bit wa;
    exp3 = '{0, 5, 36, 0, 5};
    cmp_cnt = 0; err_cnt = 0; cyc = 0; dcount = 0;
    last_g = NCORES - 1; grants_left = 0; exp_core = 0; rem = 0;

    // Reset held with traffic present
    for (int k = 0; k < NCORES; k++) reqv[k] = 5;
    drive_req();
    s_valid = 1'b1;
    s_data  = DW'(123);
    rst     = 1'b0;
    repeat (3) tick();
    clear_req();
    s_valid = 1'b0;
    rst = 1'b1;
    tick();

    // Single burst of 4 to core 3 from 8 buffered samples
    for (int v = 1; v <= 8; v++) begin
      s_valid = 1'b1;
      s_data  = DW'(v);
      tick();
    end
    s_valid = 1'b0;
    reqv[3] = 4;
    drive_req();
    start_grants(1);
    dcyc.delete();
    n = 0;
    while (grants_left > 0 && n < 40) begin tick(); n++; end
    chk("t2_timeout", grants_left, 0);
    chk("t2_consecutive", (dcyc.size() >= 4) ? dcyc[3] - dcyc[0] : -1, 3);
    chk("t2_fill", fill, 4);
    gap_check("t2");

    // Round robin among 0, 5, 36 with persistent single-sample requests
    do_reset();
    prefill(12);
    reqv[0] = 1; reqv[5] = 1; reqv[36] = 1;
    drive_req();
    gid_log.delete();
    start_grants(5);
    run_grants(200, 0);
    for (int i = 0; i < 5; i++)
      chk("t3_order", (gid_log.size() > i) ? gid_log[i] : -1, exp3[i]);

    // Starved burst: core 7 wants 3, one sample arrives every 4 clocks
    do_reset();
    reqv[7] = 3;
    drive_req();
    start_grants(1);
    dcyc.delete();
    repeat (3) tick();
    pushes = 0;
    for (int j = 0; j < 24 && grants_left > 0; j++) begin
      if ((j % 4) == 0 && pushes < 3) begin
        s_valid = 1'b1;
        s_data  = DW'(100 + pushes);
        pushes++;
      end else begin
        s_valid = 1'b0;
      end
      tick();
      if (grants_left > 0) chk("t4_stall_busy", busy, 1);
    end
    s_valid = 1'b0;
    chk("t4_timeout", grants_left, 0);
    chk("t4_space01", (dcyc.size() >= 3) ? dcyc[1] - dcyc[0] : -1, 4);
    chk("t4_space12", (dcyc.size() >= 3) ? dcyc[2] - dcyc[1] : -1, 4);
    gap_check("t4");

    // Full FIFO with s_valid held, then a single pop frees one slot
    s_valid = 1'b1;
    s_data  = DW'(500);
    for (int i = 0; i < 20; i++) begin
      wa = (exp_q.size() < DEPTH);
      tick();
      if (wa) s_data = s_data + 1'b1;
    end
    chk("t5_full_ready", s_ready, 0);
    chk("t5_full_fill", fill, 16);
    reqv[0] = 1;
    drive_req();
    start_grants(1);
    n = 0;
    while (grants_left > 0 && n < 20) begin tick(); n++; end
    chk("t5_timeout", grants_left, 0);
    chk("t5_ready_after_pop", s_ready, 1);
    chk("t5_fill_after_pop", fill, 15);
    tick();
    s_valid = 1'b0;
    chk("t5_refill", fill, 16);

    // Reset in the middle of a 15-sample burst
    do_reset();
    prefill(16);
    reqv[2] = 15;
    drive_req();
    start_grants(1);
    d0 = dcount;
    n = 0;
    while ((dcount - d0) < 6 && n < 60) begin tick(); n++; end
    chk("t6_six_delivered", dcount - d0, 6);
    clear_req();
    rst = 1'b0;
    tick();
    chk("t6_rst_valid", in_valid, 0);
    chk("t6_rst_fill", fill, 0);
    rst = 1'b1;
    reqv[0] = 1; reqv[2] = 1;
    drive_req();
    gid_log.delete();
    start_grants(1);
    run_grants(200, 50);
    chk("t6_first_grant", (gid_log.size() > 0) ? gid_log[0] : -1, 0);

    // Randomized rounds: random requester sets, lengths and push traffic
    do_reset();
    for (int r = 0; r < 8; r++) begin
      clear_req();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) reqv[$urandom_range(0, NCORES - 1)] = $urandom_range(1, 15);
      drive_req();
      start_grants($urandom_range(1, 4));
      run_grants(3000, 60);
    end
    repeat (4) tick();
    chk("final_idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
